// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared MIPS datapath constants for the multiply/divide unit
//
// Purpose: op encodings for MULT/MULTU/DIV/DIVU and the mul/div FSM state type.
// Ports: none (package).

package mips_pkg;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    FIX  = 2'b10
  } md_state_t;

endpackage

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative multiply/divide unit holding the HI/LO registers
//
// Purpose: shift-add multiply and restoring divide, one bit per cycle, with a
// final sign-fixup cycle that writes HI/LO. Also services MTHI/MTLO writes.
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   start, op         launch request and op code (MULT/MULTU/DIV/DIVU)
//   srcA, srcB        operands (register-file read ports)
//   hi_we, lo_we      MTHI / MTLO write enables, wdata is the write data
//   busy, done        operation in flight / one-cycle result pulse
//   hi, lo            current HI/LO contents

module muldiv_unit
  import mips_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] srcA,
  input  logic [WIDTH-1:0] srcB,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH);

  md_state_t        state, next_state;
  logic [CW-1:0]    cnt;
  logic [1:0]       op_r;
  logic             sign_a, sign_b;
  logic [WIDTH-1:0] raw_a;
  logic [WIDTH-1:0] mag_a, mag_b;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH:0]   rem_r;
  logic [WIDTH-1:0] quo_r;
  logic [WIDTH-1:0] hi_r, lo_r;
  logic             done_r;

  function automatic logic [WIDTH-1:0] neg(input logic [WIDTH-1:0] v);
    return ~v + 1'b1;
  endfunction

  // Operand magnitudes: op[0]=0 marks the signed variants.
  logic             in_signed;
  logic [WIDTH-1:0] abs_a, abs_b;
  assign in_signed = ~op[0];
  assign abs_a = (in_signed && srcA[WIDTH-1]) ? neg(srcA) : srcA;
  assign abs_b = (in_signed && srcB[WIDTH-1]) ? neg(srcB) : srcB;

  // Multiply step: add multiplicand into the upper half when the current
  // multiplier bit (acc[0]) is set, then shift the whole accumulator right.
  logic [WIDTH:0] mul_sum;
  assign mul_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mag_a} : '0);

  // Divide step: shift the next dividend bit into the partial remainder and
  // subtract the divisor only when it fits (restoring form).
  logic             div_ge;
  logic [WIDTH:0]   div_shift, div_diff;
  assign div_ge    = {rem_r, quo_r[WIDTH-1]} >= {2'b00, mag_b};
  assign div_shift = {rem_r[WIDTH-1:0], quo_r[WIDTH-1]};
  assign div_diff  = div_shift - {1'b0, mag_b};

  // Sign fixup. The 2*WIDTH product negate is done word-wise: low word via
  // neg(), high word inverted plus the carry out of the low word.
  logic             prod_neg, quo_neg, rem_neg, div_zero;
  logic [WIDTH-1:0] prod_lo_n, prod_hi_n;
  logic [WIDTH-1:0] fix_hi, fix_lo;
  assign prod_neg  = ~op_r[0] & (sign_a ^ sign_b);
  assign quo_neg   = ~op_r[0] & (sign_a ^ sign_b);
  assign rem_neg   = ~op_r[0] & sign_a;
  assign div_zero  = (mag_b == '0);
  assign prod_lo_n = neg(acc[WIDTH-1:0]);
  assign prod_hi_n = ~acc[2*WIDTH-1:WIDTH] + WIDTH'(acc[WIDTH-1:0] == '0);

  always_comb begin
    fix_hi = acc[2*WIDTH-1:WIDTH];
    fix_lo = acc[WIDTH-1:0];
    if (op_r[1]) begin
      if (div_zero) begin
        fix_lo = '1;
        fix_hi = raw_a;
      end else begin
        fix_lo = quo_neg ? neg(quo_r) : quo_r;
        fix_hi = rem_neg ? neg(rem_r[WIDTH-1:0]) : rem_r[WIDTH-1:0];
      end
    end else if (prod_neg) begin
      fix_hi = prod_hi_n;
      fix_lo = prod_lo_n;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start) next_state = RUN;
      RUN:     if (cnt == CW'(WIDTH - 1)) next_state = FIX;
      FIX:     next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt    <= '0;
      op_r   <= '0;
      sign_a <= 1'b0;
      sign_b <= 1'b0;
      raw_a  <= '0;
      mag_a  <= '0;
      mag_b  <= '0;
      acc    <= '0;
      rem_r  <= '0;
      quo_r  <= '0;
      hi_r   <= '0;
      lo_r   <= '0;
      done_r <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            op_r   <= op;
            sign_a <= srcA[WIDTH-1];
            sign_b <= srcB[WIDTH-1];
            raw_a  <= srcA;
            mag_a  <= abs_a;
            mag_b  <= abs_b;
            acc    <= {{WIDTH{1'b0}}, abs_b};
            rem_r  <= '0;
            quo_r  <= abs_a;
            cnt    <= '0;
          end else begin
            if (hi_we) hi_r <= wdata;
            if (lo_we) lo_r <= wdata;
          end
        end
        RUN: begin
          cnt <= cnt + 1'b1;
          if (op_r[1]) begin
            rem_r <= div_ge ? div_diff : div_shift;
            quo_r <= {quo_r[WIDTH-2:0], div_ge};
          end else begin
            acc <= {mul_sum, acc[WIDTH-1:1]};
          end
        end
        FIX: begin
          hi_r   <= fix_hi;
          lo_r   <= fix_lo;
          done_r <= 1'b1;
          cnt    <= '0;
        end
        default: ;
      endcase
    end
  end

  assign busy = (state != IDLE);
  assign done = done_r;
  assign hi   = hi_r;
  assign lo   = lo_r;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - self-checking bench for muldiv_unit

module tb_muldiv_unit;
  import mips_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic [31:0] src_a, src_b;
  logic        hi_we, lo_we;
  logic [31:0] wdata;
  logic        busy, done;
  logic [31:0] hi, lo;

  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  muldiv_unit #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op),
    .srcA(src_a), .srcB(src_b), .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  // Reference: MIPS semantics computed with 64-bit arithmetic.
  task automatic model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] ehi, output logic [31:0] elo);
    longint          sp, sa, sb, q, r;
    longint unsigned up;
    case (o)
      OP_MULT: begin
        sp = longint'($signed(a)) * longint'($signed(b));
        ehi = sp[63:32]; elo = sp[31:0];
      end
      OP_MULTU: begin
        up = {32'b0, a} * {32'b0, b};
        ehi = up[63:32]; elo = up[31:0];
      end
      default: begin
        if (b == 32'd0) begin
          elo = 32'hFFFF_FFFF; ehi = a;
        end else if (o == OP_DIV) begin
          sa = longint'($signed(a)); sb = longint'($signed(b));
          q = sa / sb; r = sa % sb;
          elo = q[31:0]; ehi = r[31:0];
        end else begin
          elo = a / b; ehi = a % b;
        end
      end
    endcase
  endtask

  // Drives a start in the current cycle and waits (bounded) for done.
  // cyc = number of edges after the start edge at which done is seen.
  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        output int cyc);
    start = 1'b1; op = o; src_a = a; src_b = b;
    @(negedge clk);
    start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
    src_a = $urandom; src_b = $urandom;
    cyc = 0;
    while (!done && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    checks++; if (hi !== 32'd0) $display("FAIL reset_hi got %h want 0", hi); else passes++;
    checks++; if (lo !== 32'd0) $display("FAIL reset_lo got %h want 0", lo); else passes++;
    checks++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else passes++;
    checks++; if (done !== 1'b0) $display("FAIL reset_done got %b want 0", done); else passes++;
  endtask

  task automatic test_multu_max();
    int busy_cnt = 0;
    int cyc = 0;
    start = 1'b1; op = OP_MULTU; src_a = 32'hFFFF_FFFF; src_b = 32'hFFFF_FFFF;
    @(negedge clk);
    start = 1'b0;
    while (!done && cyc < 100) begin
      if (busy) busy_cnt++;
      @(negedge clk);
      cyc++;
    end
    checks++; if (cyc !== 33) $display("FAIL multu_latency got %0d want 33", cyc); else passes++;
    checks++; if (busy_cnt !== 33) $display("FAIL multu_busy_cycles got %0d want 33", busy_cnt); else passes++;
    checks++; if (hi !== 32'hFFFF_FFFE) $display("FAIL multu_max_hi got %h want fffffffe", hi); else passes++;
    checks++; if (lo !== 32'h0000_0001) $display("FAIL multu_max_lo got %h want 00000001", lo); else passes++;
    checks++; if (busy !== 1'b0) $display("FAIL busy_in_done_cycle got %b want 0", busy); else passes++;
    @(negedge clk);
    checks++; if (done !== 1'b0) $display("FAIL done_one_cycle got %b want 0", done); else passes++;
  endtask

  task automatic test_mult_back_to_back();
    int cyc;
    run_op(OP_MULT, 32'hFFFF_FFFD, 32'd7, cyc);
    checks++; if (hi !== 32'hFFFF_FFFF) $display("FAIL mult_neg_hi got %h want ffffffff", hi); else passes++;
    checks++; if (lo !== 32'hFFFF_FFEB) $display("FAIL mult_neg_lo got %h want ffffffeb", lo); else passes++;
    run_op(OP_MULTU, 32'h0001_0000, 32'h0001_0000, cyc);
    checks++; if (cyc !== 33) $display("FAIL b2b_latency got %0d want 33", cyc); else passes++;
    checks++; if (hi !== 32'd1) $display("FAIL b2b_hi got %h want 1", hi); else passes++;
    checks++; if (lo !== 32'd0) $display("FAIL b2b_lo got %h want 0", lo); else passes++;
  endtask

  task automatic test_divide();
    int cyc;
    run_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, cyc);
    checks++; if (lo !== 32'hFFFF_FFFD) $display("FAIL div_neg_lo got %h want fffffffd", lo); else passes++;
    checks++; if (hi !== 32'hFFFF_FFFF) $display("FAIL div_neg_hi got %h want ffffffff", hi); else passes++;
    run_op(OP_DIVU, 32'd100, 32'd7, cyc);
    checks++; if (lo !== 32'd14) $display("FAIL divu_lo got %h want 0000000e", lo); else passes++;
    checks++; if (hi !== 32'd2) $display("FAIL divu_hi got %h want 00000002", hi); else passes++;
  endtask

  task automatic test_div_boundary();
    int cyc;
    run_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, cyc);
    checks++; if (lo !== 32'h8000_0000) $display("FAIL div_minneg_lo got %h want 80000000", lo); else passes++;
    checks++; if (hi !== 32'd0) $display("FAIL div_minneg_hi got %h want 0", hi); else passes++;
    run_op(OP_DIVU, 32'd5, 32'd0, cyc);
    checks++; if (cyc !== 33) $display("FAIL div0_latency got %0d want 33", cyc); else passes++;
    checks++; if (lo !== 32'hFFFF_FFFF) $display("FAIL divu0_lo got %h want ffffffff", lo); else passes++;
    checks++; if (hi !== 32'd5) $display("FAIL divu0_hi got %h want 5", hi); else passes++;
    run_op(OP_DIV, 32'hFFFF_FFF0, 32'd0, cyc);
    checks++; if (hi !== 32'hFFFF_FFF0) $display("FAIL div0_signed_hi got %h want fffffff0", hi); else passes++;
    checks++; if (lo !== 32'hFFFF_FFFF) $display("FAIL div0_signed_lo got %h want ffffffff", lo); else passes++;
  endtask

  task automatic test_mthi_mtlo();
    int cyc = 0;
    logic [31:0] lo_before;
    hi_we = 1'b1; wdata = 32'h0000_1234;
    @(negedge clk);
    hi_we = 1'b0;
    checks++; if (hi !== 32'h0000_1234) $display("FAIL mthi_idle got %h want 00001234", hi); else passes++;
    start = 1'b1; op = OP_MULTU; src_a = 32'd3; src_b = 32'd4;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    hi_we = 1'b1; wdata = 32'h0000_DEAD;
    @(negedge clk);
    hi_we = 1'b0;
    checks++; if (hi !== 32'h0000_1234) $display("FAIL mthi_busy got %h want 00001234", hi); else passes++;
    while (!done && cyc < 100) begin @(negedge clk); cyc++; end
    checks++; if (lo !== 32'd12) $display("FAIL mthi_busy_result got %h want 0000000c", lo); else passes++;
    @(negedge clk);
    lo_before = lo;
    start = 1'b1; op = OP_MULTU; src_a = 32'd5; src_b = 32'd6;
    lo_we = 1'b1; wdata = 32'h0000_BEEF;
    @(negedge clk);
    start = 1'b0; lo_we = 1'b0;
    checks++; if (lo !== lo_before) $display("FAIL mtlo_with_start got %h want %h", lo, lo_before); else passes++;
    checks++; if (busy !== 1'b1) $display("FAIL start_priority_busy got %b want 1", busy); else passes++;
    cyc = 0;
    while (!done && cyc < 100) begin @(negedge clk); cyc++; end
    checks++; if (lo !== 32'd30) $display("FAIL start_priority_result got %h want 0000001e", lo); else passes++;
  endtask

  task automatic test_ignored_start();
    int cyc = 0;
    start = 1'b1; op = OP_MULTU; src_a = 32'h0000_1234; src_b = 32'h0000_5678;
    @(negedge clk);
    start = 1'b0;
    while (!done && cyc < 100) begin
      if (cyc == 5) begin
        start = 1'b1; op = OP_DIV; src_a = 32'd7; src_b = 32'd0;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    checks++; if (cyc !== 33) $display("FAIL ignored_start_latency got %0d want 33", cyc); else passes++;
    checks++; if (lo !== 32'h0626_0060) $display("FAIL ignored_start_lo got %h want 06260060", lo); else passes++;
    checks++; if (hi !== 32'd0) $display("FAIL ignored_start_hi got %h want 0", hi); else passes++;
    @(negedge clk);
    checks++; if (busy !== 1'b0) $display("FAIL ignored_start_queued got %b want 0", busy); else passes++;
  endtask

  task automatic test_abort();
    int pulses = 0;
    hi_we = 1'b1; lo_we = 1'b1; wdata = 32'hA5A5_5A5A;
    @(negedge clk);
    hi_we = 1'b0; lo_we = 1'b0;
    checks++; if ({hi, lo} !== {2{32'hA5A5_5A5A}}) $display("FAIL mt_both got %h%h want a5a55a5aa5a55a5a", hi, lo); else passes++;
    start = 1'b1; op = OP_MULTU; src_a = 32'hFFFF_FFFF; src_b = 32'hFFFF_FFFF;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checks++; if (busy !== 1'b0) $display("FAIL abort_busy got %b want 0", busy); else passes++;
    checks++; if ({hi, lo} !== 64'd0) $display("FAIL abort_hilo got %h%h want 0", hi, lo); else passes++;
    repeat (40) begin
      if (done) pulses++;
      @(negedge clk);
    end
    checks++; if (pulses !== 0) $display("FAIL abort_done_pulses got %0d want 0", pulses); else passes++;
  endtask

  task automatic test_random();
    int cyc;
    logic [1:0]  o;
    logic [31:0] a, b, ehi, elo;
    for (int i = 0; i < 40; i++) begin
      o = 2'($urandom_range(0, 3));
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1: b = 32'($urandom_range(1, 9));
        2: a = 32'h8000_0000;
        3: b = 32'hFFFF_FFFF;
        default: ;
      endcase
      model(o, a, b, ehi, elo);
      run_op(o, a, b, cyc);
      checks++; if (cyc !== 33) $display("FAIL rand_latency[%0d] got %0d want 33", i, cyc); else passes++;
      checks++;
      if ({hi, lo} !== {ehi, elo})
        $display("FAIL rand_result[%0d] op=%0d a=%h b=%h got %h_%h want %h_%h", i, o, a, b, hi, lo, ehi, elo);
      else passes++;
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; op = 2'b00; src_a = '0; src_b = '0;
    hi_we = 1'b0; lo_we = 1'b0; wdata = '0;
    @(negedge clk);
    test_reset();
    test_multu_max();
    test_mult_back_to_back();
    test_divide();
    test_div_boundary();
    test_mthi_mtlo();
    test_ignored_start();
    test_abort();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative integer multiply/divide unit with architectural HI/LO registers for the MIPS datapath. It sits directly downstream of the register file and consumes its two read ports as operands for MULT, MULTU, DIV and DIVU. It holds HI/LO, which MFHI/MFLO read and MTHI/MTLO write. It raises `busy` so the control unit can stall while an operation is in flight.

## Interface
Parameters:
- `WIDTH`, 32: operand width; HI and LO are each `WIDTH` bits.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high.
- `start`  in  1  launch the operation in `op`; sampled only when `busy`=0.
- `op`  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- `srcA`  in  WIDTH  multiplicand or dividend (register-file ReadData1).
- `srcB`  in  WIDTH  multiplier or divisor (register-file ReadData2).
- `hi_we`, `lo_we`  in  1  MTHI / MTLO write enables.
- `wdata`  in  WIDTH  MTHI/MTLO data.
- `busy`  out  1  operation in flight.
- `done`  out  1  one-cycle pulse when HI/LO take the result.
- `hi`, `lo`  out  WIDTH  current HI/LO register contents.

## Operation
- Reset values:
  - `hi` = `lo` = 0.
  - `busy` = 0, `done` = 0.
  - State is IDLE and the iteration counter is 0.
- States and transitions:
  - IDLE: `start` moves to RUN.
  - RUN: stays for `WIDTH` iterations, then moves to FIX.
  - FIX: moves to IDLE.
- On accepting `start`:
  - Latch `op`.
  - Latch the magnitudes of `srcA` and `srcB`. Signed ops take the two's-complement absolute value; unsigned ops use the raw value.
  - Latch the result-sign flags:
    - product sign = signA XOR signB;
    - quotient sign = signA XOR signB;
    - remainder sign = signA.
- RUN, multiply: shift-add, one multiplier bit per cycle, into a 2·WIDTH accumulator.
- RUN, divide: restoring division, one quotient bit per cycle. Partial remainder is WIDTH+1 bits.
- FIX stage:
  - Apply sign fixup: negate the 2·WIDTH product, or negate quotient and remainder independently.
  - Write HI/LO. Multiply: HI = upper word, LO = lower word. Divide: LO = quotient, HI = remainder.
  - Pulse `done`.
- Boundary cases:
  - Divide by zero, any divide op: LO = all ones, HI = `srcA` unmodified. No sign fixup. Same latency.
  - DIV of most-negative by −1: LO = 0x8000_0000, HI = 0 (natural result, no trap).
- MTHI/MTLO:
  - In IDLE with `start`=0: `hi_we`/`lo_we` load `wdata` into HI/LO on the next edge. Both may be asserted together.
  - Ignored while `busy`=1.
  - Ignored when `start` is asserted in the same cycle (start has priority).
- `start` while `busy`=1 is ignored; operand inputs are don't-care.
- HI/LO hold their old values throughout RUN and are updated only in FIX.

## Timing
- Edge 0: `start` is sampled in IDLE. After edge 0, `busy`=1.
- Edges 1..WIDTH: iterations.
- Edge WIDTH+1: FIX. After this edge, HI/LO hold the result, `done`=1 for exactly one cycle, and `busy`=0.
- Latency: the result is visible WIDTH+1 cycles after the start edge (33 for WIDTH=32).
- `busy` is combinationally `state != IDLE` and reads 0 during the `done` cycle.
- Back-to-back: a new `start` may be accepted in the `done` cycle.
- `reset` mid-operation: at the next edge, state returns to IDLE, HI/LO clear to 0, `busy` = `done` = 0. No `done` pulse is issued for the aborted operation.
- MTHI/MTLO write latency: 1 cycle.

## Structure
- Shared package `mips_pkg`:
  - op encodings `OP_MULT`, `OP_MULTU`, `OP_DIV`, `OP_DIVU`;
  - state enum IDLE / RUN / FIX.
- Control decode and the register-file interface use the same constants.
- Single module; no sub-module required.
- Two's-complement negate/abs is a local function used for both operands and the fixup.

## Test plan
- MULTU 0xFFFF_FFFF × 0xFFFF_FFFF → HI = 0xFFFF_FFFE, LO = 0x0000_0001; `done` exactly 33 cycles after the start edge; `busy` high for 33 cycles.
- MULT 0xFFFF_FFFD (−3) × 7 → HI = 0xFFFF_FFFF, LO = 0xFFFF_FFEB. Then back-to-back start in the `done` cycle: MULTU 0x10000 × 0x10000 → HI = 1, LO = 0.
- DIV −7 / 2 → LO = 0xFFFF_FFFD, HI = 0xFFFF_FFFF. DIVU 100 / 7 → LO = 14, HI = 2.
- DIV 0x8000_0000 / 0xFFFF_FFFF → LO = 0x8000_0000, HI = 0. DIVU 5 / 0 → LO = 0xFFFF_FFFF, HI = 5.
- MTHI 0x1234 in IDLE → `hi` = 0x1234 next cycle. The same write while busy → `hi` unchanged. `start` together with `lo_we` → write dropped, operation runs.
- Start MULTU, extra `start` at cycle 5 → ignored. Assert `reset` at cycle 10 → next cycle `busy` = 0, HI = LO = 0, no `done` pulse afterward.
